// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-phase state encoding
// and response codes used by requester and completer.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating ACCESS wait-state counter for the PREADY watchdog.
// clk_i/rst_ni clock+async reset; clr_i restart; en_i count; expired_o at limit.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] MAX = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic WD_ON = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the ACCESS cycle that would be the last allowed wait.
  assign expired_o = WD_ON && (cnt_q == LAST);

endmodule

// File: rtl/apb_master.sv
// APB requester: command/response handshake to APB SETUP/ACCESS transfers.
// Ports: i_cmd_* request, o_rsp_* one-cycle response, P* APB bus signals.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_write,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic                  o_rsp_err,
  output logic                  o_rsp_timeout,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PSELx,
  output logic                  PENABLE,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_t            state_q;
  logic                  ready_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  rsp_tmo_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  expired;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (i_clk),
    .rst_ni   (i_reset_n),
    .clr_i    (state_q == SETUP),
    .en_i     ((state_q == ACCESS) && !PREADY),
    .expired_o(expired)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (i_cmd_valid && ready_q) begin
            paddr_q  <= i_cmd_addr;
            pwrite_q <= i_cmd_write;
            pwdata_q <= i_cmd_wdata;
            ready_q  <= 1'b0;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // Completion is checked first so PREADY beats the watchdog.
          if (PREADY) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= PSLVERR ? APB_RESP_ERR : APB_RESP_OKAY;
            rsp_tmo_q   <= 1'b0;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else if (expired) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= APB_RESP_ERR;
            rsp_tmo_q   <= 1'b1;
            rsp_rdata_q <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign o_cmd_ready   = ready_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_rsp_timeout = rsp_tmo_q;
  assign PADDR         = paddr_q;
  assign PWRITE        = pwrite_q;
  assign PWDATA        = pwdata_q;
  assign PSELx         = psel_q;
  assign PENABLE       = penable_q;

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester: turns a simple command/response handshake from local logic into compliant APB SETUP/ACCESS transfers.
- Drives the bus toward apb_slave instances, with wait-state support via PREADY and error return via PSLVERR.
- A PREADY watchdog aborts hung transfers so a stuck slave cannot deadlock the initiator.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and i_cmd_addr
- DATA_WIDTH, 32, width of PWDATA, PRDATA, i_cmd_wdata, o_rsp_rdata
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the watchdog

Ports:
- i_clk  in  1  APB clock, rising-edge
- i_reset_n  in  1  reset, asynchronous assert, active-low (fixed)
- i_cmd_valid  in  1  command request
- o_cmd_ready  out  1  command accepted when valid && ready
- i_cmd_write  in  1  1 = write, 0 = read
- i_cmd_addr  in  ADDR_WIDTH  transfer address
- i_cmd_wdata  in  DATA_WIDTH  write data
- o_rsp_valid  out  1  one-cycle response pulse
- o_rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- o_rsp_err  out  1  PSLVERR or timeout
- o_rsp_timeout  out  1  response caused by the watchdog
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  DATA_WIDTH  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- All outputs are registered. Async reset clears every output to 0 and sets state to IDLE.
- IDLE:
  - o_cmd_ready = 1.
  - On accept, latch addr, write and wdata into PADDR, PWRITE and PWDATA, and go to SETUP.
  - PSELx = 0, PENABLE = 0.
  - PADDR, PWRITE and PWDATA hold their last values (never X).
- SETUP: lasts exactly one cycle. PSELx = 1, PENABLE = 0. Unconditionally goes to ACCESS.
- ACCESS:
  - PSELx = 1, PENABLE = 1. PADDR, PWRITE and PWDATA stay stable from SETUP through the final ACCESS cycle.
  - Wait counter clears on entry and increments on each ACCESS cycle sampled with PREADY = 0.
  - PREADY = 1 sampled:
    - Next cycle: o_rsp_valid = 1, o_rsp_err = PSLVERR, o_rsp_timeout = 0.
    - o_rsp_rdata = PRDATA for reads, 0 for writes.
    - State returns to IDLE.
  - Timeout (TIMEOUT_CYCLES != 0, counter == TIMEOUT_CYCLES - 1, PREADY = 0):
    - Next cycle: o_rsp_valid = 1, o_rsp_err = 1, o_rsp_timeout = 1, o_rsp_rdata = 0.
    - State returns to IDLE.
  - If PREADY = 1 on the timeout cycle, the normal completion wins.
- Latency and throughput:
  - Accept at edge k → SETUP in cycle k+1 → ACCESS in k+2.
  - With zero wait states, o_rsp_valid and o_cmd_ready are both high in cycle k+3.
  - Maximum rate is one transfer per 3 cycles.
  - A command presented in the same cycle as o_rsp_valid is accepted.
- Response channel: o_rsp_* are valid only while o_rsp_valid = 1. The consumer has no backpressure.
- PSLVERR is ignored unless sampled together with PREADY = 1 in ACCESS.
- Reset mid-transfer: PSELx and PENABLE drop immediately (async), no response is issued, and the transfer is lost.
- Counter width is $clog2(TIMEOUT_CYCLES+1) and it saturates, so it never wraps.

Decomposition:
- Package apb_pkg holds:
  - the apb_state_t enum {IDLE, SETUP, ACCESS} (2-bit), shared with apb_slave;
  - localparam APB_RESP_OKAY = 1'b0 and APB_RESP_ERR = 1'b1.
- One sub-module, apb_wait_timer: counter with clear/enable/expired, parameterized by TIMEOUT_CYCLES.

Test Plan:
- Reset: hold i_reset_n = 0 → all outputs 0, o_cmd_ready = 0. Release → o_cmd_ready = 1 next cycle.
- Zero-wait write:
  - Stimulus: cmd write addr 0x4, wdata 0xDEADBEEF, PREADY tied 1.
  - Response: SETUP (PSELx = 1, PENABLE = 0) then ACCESS (1, 1) with PADDR = 0x4 and PWDATA = 0xDEADBEEF.
  - Then o_rsp_valid = 1, err = 0, rdata = 0 in cycle k+3.
- Read with 2 wait states:
  - Stimulus: addr 0x2, PREADY low for 2 ACCESS cycles, then high with PRDATA = 0x12345678.
  - Response: o_rsp_rdata = 0x12345678, err = 0, with PADDR/PWRITE stable across all 3 ACCESS cycles.
- Slave error:
  - Stimulus: read addr 0x100, PREADY = 1, PSLVERR = 1.
  - Response: o_rsp_err = 1, o_rsp_timeout = 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 4, PREADY held 0.
  - Response: exactly 4 ACCESS cycles, then o_rsp_valid = 1, err = 1, timeout = 1, rdata = 0, and PSELx = 0.
- Reset mid-ACCESS: assert i_reset_n = 0 during ACCESS → PSELx and PENABLE go 0 without a clock edge, and no o_rsp_valid follows.
